if_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction cache. It owns the program counter and issues one word request at a time on the cache's CPU-side valid/ready port. Returned instructions are buffered with their PC in a small FIFO toward decode. Branch/jump redirects from later stages are absorbed without aborting an in-flight cache request.

---
 rtl/if_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one I-cache word request at a time,
// and buffers returned {pc, inst} pairs in a small FIFO toward decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cpu_req_addr,
    output logic        cpu_req_valid,
    input  logic [31:0] cpu_req_data,
    input  logic        cpu_req_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CALC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_STALL = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_req_pc;
    logic [31:0]       r_redir_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_mem_pc   [FIFO_DEPTH];
    logic [31:0]       r_mem_inst [FIFO_DEPTH];

    logic [31:0]       w_redir_target;
    logic              w_not_empty;
    logic              w_pop;
    logic              w_push;
    logic [CALC_W-1:0] w_cnt_after_pop;
    logic [CALC_W-1:0] w_cnt_after_push;
    logic              w_space;
    logic              w_room_after_push;

    assign w_redir_target    = redirect_pc & ~32'h0000_0003;
    assign w_not_empty       = (r_count != CNT_W'(0));
    assign w_pop             = w_not_empty & id_ready & ~redirect_valid;
    // Only a completion in FETCH without a competing redirect lands in the buffer.
    assign w_push            = (r_state == ST_FETCH) & cpu_req_ready & ~redirect_valid;
    assign w_cnt_after_pop   = CALC_W'(r_count) - CALC_W'(w_pop);
    assign w_cnt_after_push  = w_cnt_after_pop + CALC_W'(1);
    assign w_space           = (w_cnt_after_pop < CALC_W'(FIFO_DEPTH));
    assign w_room_after_push = (w_cnt_after_push < CALC_W'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_STALL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STALL: begin
                if (w_space) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (!cpu_req_ready) begin
                        w_state_nxt = ST_DROP;
                    end
                end else if (cpu_req_ready && !w_room_after_push) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_DROP: begin
                if (cpu_req_ready) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_STALL;
        endcase
    end

    // Outputs: request port decoded from state, decode port from the FIFO head.
    always_comb begin
        cpu_req_valid = (r_state != ST_STALL);
        cpu_req_addr  = r_req_pc;
        id_valid      = w_not_empty;
        id_pc         = 32'h0;
        id_inst       = 32'h0;
        if (w_not_empty) begin
            id_pc   = r_mem_pc[r_rd_ptr];
            id_inst = r_mem_inst[r_rd_ptr];
        end
    end

    // Request PC and pending redirect target; req_pc only moves on completion or from STALL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_pc   <= RESET_PC;
            r_redir_pc <= 32'h0;
        end else begin
            case (r_state)
                ST_STALL: begin
                    if (redirect_valid) begin
                        r_req_pc <= w_redir_target;
                    end
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        if (cpu_req_ready) begin
                            r_req_pc <= w_redir_target;
                        end else begin
                            r_redir_pc <= w_redir_target;
                        end
                    end else if (cpu_req_ready) begin
                        r_req_pc <= r_req_pc + 32'd4;
                    end
                end
                ST_DROP: begin
                    if (cpu_req_ready) begin
                        r_req_pc <= redirect_valid ? w_redir_target : r_redir_pc;
                    end else if (redirect_valid) begin
                        r_redir_pc <= w_redir_target;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO control; a redirect flushes and wins over same-cycle push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else if (redirect_valid) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= CNT_W'(w_cnt_after_pop + CALC_W'(w_push));
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
            r_mem_inst[r_wr_ptr] <= cpu_req_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected {pc, inst} popped by a
// decode-side monitor, plus point checks on the cache request port.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_valid;
    logic [31:0] cpu_req_data = 32'h0;
    logic        cpu_req_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;

    // Second instance exercising a wrapping reset PC.
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_data = 32'h0;
    logic        w_ready = 1'b0;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_inst;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid),
        .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst),
        .cpu_req_addr(w_addr), .cpu_req_valid(w_valid),
        .cpu_req_data(w_data), .cpu_req_ready(w_ready),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_inst(w_id_inst), .id_ready(1'b0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // Decode-side monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && id_valid && id_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h expected none", id_pc, id_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({id_pc, id_inst} !== e) begin
                    failures++;
                    $display("FAIL pop: got pc=%h inst=%h expected pc=%h inst=%h",
                             id_pc, id_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        // Reset held for three cycles.
        repeat (3) cyc();
        chk("rst_valid", 32'(cpu_req_valid), 32'h0);
        chk("rst_addr", cpu_req_addr, 32'h0);
        chk("rst_id_valid", 32'(id_valid), 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        rst = 1'b1;

        // Cycle after the first rising edge out of reset: request at RESET_PC.
        cyc();
        chk("start_valid", 32'(cpu_req_valid), 32'h1);
        chk("start_addr", cpu_req_addr, 32'h0);
        chk("wrap_start_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_start_valid", 32'(w_valid), 32'h1);
        w_ready = 1'b1; w_data = 32'h0000_00AA;
        id_ready = 1'b1;
        cpu_req_ready = 1'b1; cpu_req_data = 32'h0000_0013; expect_push(32'h0, 32'h0000_0013);

        // Streaming with a always-ready cache and draining decode.
        cyc();
        w_ready = 1'b0;
        chk("wrap_next_addr", w_addr, 32'h0);
        chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_inst", w_id_inst, 32'h0000_00AA);
        chk("first_id_valid", 32'(id_valid), 32'h1);
        chk("first_id_pc", id_pc, 32'h0);
        chk("first_id_inst", id_inst, 32'h0000_0013);
        chk("stream_addr4", cpu_req_addr, 32'h4);
        cpu_req_data = 32'h0010_0093; expect_push(32'h4, 32'h0010_0093);
        cyc();
        chk("stream_addr8", cpu_req_addr, 32'h8);
        chk("stream_id_pc4", id_pc, 32'h4);
        cpu_req_data = 32'h0020_0113; expect_push(32'h8, 32'h0020_0113);
        cyc();
        chk("stream_addrC", cpu_req_addr, 32'hC);
        chk("stream_id_pc8", id_pc, 32'h8);
        cpu_req_data = 32'h0030_0193; expect_push(32'hC, 32'h0030_0193);
        cyc();
        chk("stream_id_pcC", id_pc, 32'hC);
        chk("stream_addr10", cpu_req_addr, 32'h10);
        cpu_req_ready = 1'b0;
        cyc();
        chk("drained_id_valid", 32'(id_valid), 32'h0);

        // Backpressure: two completions fill the 2-entry buffer and stall fetch.
        id_ready = 1'b0;
        cpu_req_ready = 1'b1; cpu_req_data = 32'h0000_0055; expect_push(32'h10, 32'h0000_0055);
        cyc();
        chk("bp_addr14", cpu_req_addr, 32'h14);
        chk("bp_valid_still", 32'(cpu_req_valid), 32'h1);
        cpu_req_data = 32'h0000_0066; expect_push(32'h14, 32'h0000_0066);
        cyc();
        cpu_req_ready = 1'b0;
        chk("bp_stall_valid", 32'(cpu_req_valid), 32'h0);
        chk("bp_stall_addr", cpu_req_addr, 32'h18);
        cyc();
        chk("bp_stall_hold", 32'(cpu_req_valid), 32'h0);
        chk("bp_head_pc", id_pc, 32'h10);
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        chk("bp_resume_valid", 32'(cpu_req_valid), 32'h1);
        chk("bp_resume_addr", cpu_req_addr, 32'h18);
        chk("bp_head_after_pop", id_pc, 32'h14);

        // Redirect while the request at 0x18 is pending.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        exp_q.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("rd_flush_id_valid", 32'(id_valid), 32'h0);
        chk("rd_addr_held", cpu_req_addr, 32'h18);
        chk("rd_valid_held", 32'(cpu_req_valid), 32'h1);
        cpu_req_ready = 1'b1; cpu_req_data = 32'h0000_DEAD;
        cyc();
        chk("rd_new_addr", cpu_req_addr, 32'h200);
        chk("rd_dead_discarded", 32'(id_valid), 32'h0);

        // Redirect coincident with a completion.
        cpu_req_data = 32'h0000_0011; expect_push(32'h200, 32'h0000_0011);
        cyc();
        chk("co_id_pc", id_pc, 32'h200);
        chk("co_addr204", cpu_req_addr, 32'h204);
        cpu_req_data = 32'h0000_0022;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        exp_q.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("co_no_push", 32'(id_valid), 32'h0);
        chk("co_addr40", cpu_req_addr, 32'h40);
        chk("co_valid", 32'(cpu_req_valid), 32'h1);
        cpu_req_data = 32'h0000_0033; expect_push(32'h40, 32'h0000_0033);
        cyc();
        cpu_req_ready = 1'b0;
        chk("co_id_inst33", id_inst, 32'h0000_0033);

        // Redirect and pop in the same cycle, then a second redirect while dropping.
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        exp_q.delete();
        cyc();
        id_ready = 1'b0;
        chk("rp_id_valid", 32'(id_valid), 32'h0);
        chk("rp_id_pc", id_pc, 32'h0);
        chk("rp_id_inst", id_inst, 32'h0);
        chk("rp_addr_held", cpu_req_addr, 32'h44);
        redirect_pc = 32'h0000_0101;
        cyc();
        redirect_valid = 1'b0;
        chk("drop_addr_held", cpu_req_addr, 32'h44);
        cpu_req_ready = 1'b1; cpu_req_data = 32'h0000_0099;
        cyc();
        chk("drop_new_addr", cpu_req_addr, 32'h100);
        chk("drop_discarded", 32'(id_valid), 32'h0);

        // Wrap: redirect to the top word, next fetch address wraps to zero.
        cpu_req_data = 32'h0000_0077;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        exp_q.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_top_addr", cpu_req_addr, 32'hFFFF_FFFC);
        cpu_req_data = 32'h0000_00AA; expect_push(32'hFFFF_FFFC, 32'h0000_00AA);
        cyc();
        cpu_req_ready = 1'b0;
        chk("wrap_zero_addr", cpu_req_addr, 32'h0);
        chk("wrap_head_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_head_inst", id_inst, 32'h0000_00AA);

        // Asynchronous reset mid-request.
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 32'(cpu_req_valid), 32'h0);
        chk("arst_id_valid", 32'(id_valid), 32'h0);
        chk("arst_addr", cpu_req_addr, 32'h0);
        chk("arst_wrap_id_valid", 32'(w_id_valid), 32'h0);
        chk("arst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        chk("rerun_valid", 32'(cpu_req_valid), 32'h1);
        chk("rerun_addr", cpu_req_addr, 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
